// File: rtl/simple_fifo_drain.sv
// simple_fifo_drain
// Drain stage sitting behind the simple bypass FIFO. It decides when to pop
// from the FIFO's count and push, and it captures the FIFO's same-cycle
// data_out into a registered 2-entry skid buffer. The consumer sees a
// registered valid/ready interface, so out_ready never reaches fifo_pop
// combinationally.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   fifo_cnt    FIFO occupancy, reflects last cycle's push/pop
//   fifo_push   FIFO push this cycle (allows a bypass pop from an empty FIFO)
//   fifo_data   FIFO data_out, valid in the same cycle as fifo_pop
//   fifo_pop    pop request to the FIFO (combinational)
//   out_valid   output entry valid (registered)
//   out_data    output entry data (registered)
//   out_ready   consumer ready; a transfer happens on out_valid && out_ready
//   pop_count   (SIMPLE_FIFO_DRAIN_STATS_EN only) saturating pop counter
//   stall_count (SIMPLE_FIFO_DRAIN_STATS_EN only) saturating stall counter
//
// Optional feature macro: SIMPLE_FIFO_DRAIN_STATS_EN
//
// state | meaning
// ------+------------------------------------------
// EMPTY | no entries held
// HALF  | out_reg holds the oldest entry
// FULL  | out_reg oldest, skid_reg holds the next one

module simple_fifo_drain #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
   input  logic                       fifo_push,
   input  logic [WIDTH-1:0]           fifo_data,
   output logic                       fifo_pop,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready
`ifdef SIMPLE_FIFO_DRAIN_STATS_EN
   ,
   output logic [15:0]                pop_count,
   output logic [15:0]                stall_count
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_reg_q, out_reg_d;
   logic [WIDTH-1:0] skid_reg_q, skid_reg_d;
   logic             out_valid_q, out_valid_d;
   logic             avail;
   logic             accept;

   // fifo_push covers the bypass case: popping an empty FIFO during a push.
   assign avail    = (fifo_cnt != '0) || fifo_push;
   assign fifo_pop = avail && (state_q != FULL) && !reset;
   assign accept   = out_valid_q && out_ready;

   always_comb begin
      state_d    = state_q;
      out_reg_d  = out_reg_q;
      skid_reg_d = skid_reg_q;
      unique case (state_q)
         EMPTY: begin
            if (fifo_pop) begin
               state_d   = HALF;
               out_reg_d = fifo_data;
            end
         end
         HALF: begin
            if (fifo_pop && accept) begin
               out_reg_d = fifo_data;
            end else if (fifo_pop) begin
               state_d    = FULL;
               skid_reg_d = fifo_data;
            end else if (accept) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // fifo_pop is already 0 here, so nothing new is captured.
            if (accept) begin
               state_d   = HALF;
               out_reg_d = skid_reg_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         out_reg_q   <= '0;
         skid_reg_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_reg_q   <= out_reg_d;
         skid_reg_q  <= skid_reg_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_reg_q;

`ifdef SIMPLE_FIFO_DRAIN_STATS_EN
   logic [15:0] pop_count_q, pop_count_d;
   logic [15:0] stall_count_q, stall_count_d;

   always_comb begin
      pop_count_d   = pop_count_q;
      stall_count_d = stall_count_q;
      if (fifo_pop && (pop_count_q != 16'hFFFF))
         pop_count_d = pop_count_q + 16'd1;
      if (out_valid_q && !out_ready && (stall_count_q != 16'hFFFF))
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pop_count_q   <= '0;
         stall_count_q <= '0;
      end else begin
         pop_count_q   <= pop_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign pop_count   = pop_count_q;
   assign stall_count = stall_count_q;
`endif

`ifndef SYNTHESIS
   a_pop_needs_avail: assert property (@(posedge clk) fifo_pop |-> avail);
   a_state_legal: assert property (@(posedge clk) disable iff (reset)
      state_q inside {EMPTY, HALF, FULL});
   a_out_data_hold: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> $stable(out_data));
`endif

endmodule
